alu_result_stage: RTL and testbench

//  Execute-to-writeback pipeline stage directly downstream of the ALU.
//  - Captures accum_out plus destination tag; derives zero/negative flags.
//  - Presents the result to writeback through a valid/ready handshake.
//  - A 2-entry skid buffer gives full throughput with a registered in_ready.
//  - Exposes the youngest held result as a forwarding source for operand bypass.

---
 rtl/alu_result_stage.sv | 139 +++++++++++++
 tb/tb_alu_result_stage.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// Execute-to-writeback result stage: two-entry skid buffer with registered in_ready,
// zero/negative flag capture, forwarding of the youngest held result and a retire counter.
module alu_result_stage #(
   parameter int unsigned DATAPATH_WIDTH = 64,
   parameter int unsigned REG_ADDR_W     = 5,
   parameter int unsigned CNT_W          = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATAPATH_WIDTH-1:0] in_result,
   input  logic [REG_ADDR_W-1:0]     in_dest,
   input  logic                      in_wr_en,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATAPATH_WIDTH-1:0] out_result,
   output logic [REG_ADDR_W-1:0]     out_dest,
   output logic                      out_wr_en,
   output logic                      out_zero,
   output logic                      out_neg,
   output logic                      fwd_valid,
   output logic [REG_ADDR_W-1:0]     fwd_dest,
   output logic [DATAPATH_WIDTH-1:0] fwd_result,
   output logic [CNT_W-1:0]          retire_count
);

   typedef enum logic [1:0] {StEmpty, StBusy, StFull} state_e;

   typedef struct packed {
      logic [DATAPATH_WIDTH-1:0] result;
      logic [REG_ADDR_W-1:0]     dest;
      logic                      wr_en;
      logic                      zero;
      logic                      neg;
   } entry_t;

   state_e           state_q, state_d;
   entry_t           main_q, main_d;
   entry_t           skid_q, skid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   entry_t in_entry;
   logic   in_fire;
   logic   out_fire;
   logic   in_take;

   always_comb begin
      in_entry.result = in_result;
      in_entry.dest   = in_dest;
      in_entry.wr_en  = in_wr_en;
      in_entry.zero   = (in_result == '0);
      in_entry.neg    = in_result[DATAPATH_WIDTH-1];
   end

   // Handshake signals come from the state register only, never from out_ready.
   assign in_ready  = (state_q != StFull);
   assign out_valid = (state_q != StEmpty);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;
   // A flush discards any result accepted in the same cycle.
   assign in_take   = in_fire & ~flush;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      cnt_d   = cnt_q + CNT_W'(out_fire);
      unique case (state_q)
         StEmpty: begin
            if (in_take) begin
               main_d  = in_entry;
               state_d = StBusy;
            end
         end
         StBusy: begin
            if (in_take && out_fire) begin
               main_d = in_entry;
            end else if (in_take) begin
               skid_d  = in_entry;
               state_d = StFull;
            end else if (out_fire) begin
               state_d = StEmpty;
            end
         end
         StFull: begin
            if (out_fire) begin
               main_d  = skid_q;
               state_d = StBusy;
            end
         end
         default: state_d = StEmpty;
      endcase
      if (flush) begin
         state_d = StEmpty;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StEmpty;
         main_q  <= '0;
         skid_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         cnt_q   <= cnt_d;
      end
   end

   assign out_result   = main_q.result;
   assign out_dest     = main_q.dest;
   assign out_wr_en    = main_q.wr_en;
   assign out_zero     = main_q.zero;
   assign out_neg      = main_q.neg;
   assign retire_count = cnt_q;

   // The youngest held entry is the bypass source: skid when full, otherwise main.
   always_comb begin
      fwd_valid  = 1'b0;
      fwd_dest   = main_q.dest;
      fwd_result = main_q.result;
      unique case (state_q)
         StBusy: begin
            fwd_valid = main_q.wr_en;
         end
         StFull: begin
            fwd_valid  = skid_q.wr_en;
            fwd_dest   = skid_q.dest;
            fwd_result = skid_q.result;
         end
         default: fwd_valid = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed scenarios plus random traffic, all checked against a
// queue-based model of an in-order two-deep buffer.
module tb_alu_result_stage;

   localparam int unsigned DW    = 64;
   localparam int unsigned RW    = 5;
   localparam int unsigned CNT_W = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_result;
   logic [RW-1:0] in_dest;
   logic          in_wr_en;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_result;
   logic [RW-1:0] out_dest;
   logic          out_wr_en;
   logic          out_zero;
   logic          out_neg;
   logic          fwd_valid;
   logic [RW-1:0] fwd_dest;
   logic [DW-1:0] fwd_result;
   logic [CNT_W-1:0] retire_count;

   alu_result_stage #(
      .DATAPATH_WIDTH (DW),
      .REG_ADDR_W     (RW),
      .CNT_W          (CNT_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_result    (in_result),
      .in_dest      (in_dest),
      .in_wr_en     (in_wr_en),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_result   (out_result),
      .out_dest     (out_dest),
      .out_wr_en    (out_wr_en),
      .out_zero     (out_zero),
      .out_neg      (out_neg),
      .fwd_valid    (fwd_valid),
      .fwd_dest     (fwd_dest),
      .fwd_result   (fwd_result),
      .retire_count (retire_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] res;
      logic [RW-1:0] dest;
      logic          wr;
   } ent_t;

   ent_t mq[$];
   int   cnt;
   int   vectors;
   int   miscompares;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] exp_cnt();
      return 64'(cnt % (1 << CNT_W));
   endfunction

   task automatic check_all();
      check_eq("in_ready", 64'(in_ready), 64'(mq.size() < 2));
      check_eq("out_valid", 64'(out_valid), 64'(mq.size() != 0));
      check_eq("retire_count", 64'(retire_count), exp_cnt());
      if (mq.size() != 0) begin
         check_eq("out_result", out_result, mq[0].res);
         check_eq("out_dest", 64'(out_dest), 64'(mq[0].dest));
         check_eq("out_wr_en", 64'(out_wr_en), 64'(mq[0].wr));
         check_eq("out_zero", 64'(out_zero), 64'(mq[0].res == 0));
         check_eq("out_neg", 64'(out_neg), 64'(mq[0].res[DW-1]));
         check_eq("fwd_valid", 64'(fwd_valid), 64'(mq[mq.size()-1].wr));
         if (mq[mq.size()-1].wr) begin
            check_eq("fwd_dest", 64'(fwd_dest), 64'(mq[mq.size()-1].dest));
            check_eq("fwd_result", fwd_result, mq[mq.size()-1].res);
         end
      end else begin
         check_eq("fwd_valid_empty", 64'(fwd_valid), 64'd0);
      end
   endtask

   // Called at a negedge: drive, advance one cycle in DUT and model, check at next negedge.
   task automatic step(input logic iv, input logic [DW-1:0] r, input logic [RW-1:0] d,
                       input logic w, input logic ordy, input logic fl);
      bit in_f, out_f;
      ent_t e;
      in_valid  = iv;
      in_result = r;
      in_dest   = d;
      in_wr_en  = w;
      out_ready = ordy;
      flush     = fl;
      in_f  = iv && (mq.size() < 2);
      out_f = ordy && (mq.size() != 0);
      e.res = r;
      e.dest = d;
      e.wr = w;
      @(posedge clk);
      if (out_f) begin
         void'(mq.pop_front());
         cnt++;
      end
      if (fl) mq.delete();
      else if (in_f) mq.push_back(e);
      @(negedge clk);
      check_all();
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      mq.delete();
      cnt = 0;
      check_all();
      check_eq("reset_out_result", out_result, 64'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check_all();
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      cnt         = 0;
      reset       = 1'b1;
      flush       = 1'b0;
      in_valid    = 1'b0;
      in_result   = '0;
      in_dest     = '0;
      in_wr_en    = 1'b0;
      out_ready   = 1'b0;
      @(negedge clk);
      check_all();
      reset = 1'b0;

      // Streaming 1..8 at full rate.
      for (int i = 1; i <= 8; i++) begin
         step(1'b1, 64'(i), RW'(i), 1'b1, 1'b1, 1'b0);
         check_eq("stream_in_ready", 64'(in_ready), 64'd1);
         check_eq("stream_out", out_result, 64'(i));
      end
      step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      check_eq("stream_count", 64'(retire_count), 64'd8);

      // Backpressure then ordered drain.
      step(1'b1, 64'd5, 5'd3, 1'b1, 1'b0, 1'b0);
      step(1'b1, 64'd7, 5'd4, 1'b1, 1'b0, 1'b0);
      check_eq("bp_in_ready", 64'(in_ready), 64'd0);
      check_eq("bp_out_result", out_result, 64'd5);
      check_eq("bp_fwd_result", fwd_result, 64'd7);
      step(1'b1, 64'd99, 5'd9, 1'b1, 1'b0, 1'b0);
      check_eq("bp_hold", out_result, 64'd5);
      step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      check_eq("bp_second", out_result, 64'd7);
      step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);

      // Flags.
      step(1'b1, 64'd0, 5'd1, 1'b0, 1'b0, 1'b0);
      check_eq("flag_zero", 64'(out_zero), 64'd1);
      check_eq("flag_zero_neg", 64'(out_neg), 64'd0);
      step(1'b1, 64'h8000_0000_0000_0000, 5'd2, 1'b1, 1'b1, 1'b0);
      check_eq("flag_neg", 64'(out_neg), 64'd1);
      check_eq("flag_neg_zero", 64'(out_zero), 64'd0);
      step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);

      // Flush while full with in_valid high.
      step(1'b1, 64'd11, 5'd5, 1'b1, 1'b0, 1'b0);
      step(1'b1, 64'd12, 5'd6, 1'b1, 1'b0, 1'b0);
      step(1'b1, 64'd13, 5'd7, 1'b1, 1'b0, 1'b1);
      check_eq("flush_full_valid", 64'(out_valid), 64'd0);
      check_eq("flush_full_fwd", 64'(fwd_valid), 64'd0);

      // Flush together with an out handshake still retires.
      step(1'b1, 64'd21, 5'd8, 1'b1, 1'b0, 1'b0);
      step(1'b1, 64'd22, 5'd9, 1'b1, 1'b1, 1'b1);
      check_eq("flush_fire_valid", 64'(out_valid), 64'd0);

      // Reset in the middle of a full buffer.
      step(1'b1, 64'd31, 5'd10, 1'b1, 1'b0, 1'b0);
      step(1'b1, 64'd32, 5'd11, 1'b1, 1'b0, 1'b0);
      do_reset();

      // Counter wrap: 17 retirements on a 4-bit counter.
      for (int i = 0; i < 17; i++) step(1'b1, 64'(i + 100), RW'(i), 1'b1, 1'b1, 1'b0);
      step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      check_eq("wrap_count", 64'(retire_count), 64'd1);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         logic [DW-1:0] r;
         case ($urandom_range(0, 3))
            0: r = '0;
            1: r = {1'b1, 63'($urandom())};
            default: r = {32'($urandom()), 32'($urandom())};
         endcase
         if (i == 1500) do_reset();
         step(1'($urandom_range(0, 3) != 0), r, RW'($urandom()), 1'($urandom()),
              1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
